mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 64-bit five-stage pipeline. It consumes the EX/MEM pipeline register outputs, runs a ready-handshaked data-memory access, and resolves branches. It drives the PC-select, branch target and flush back to the front of the pipeline, and holds the MEM/WB register contents for write-back. Multi-cycle memory accesses stall the upstream pipeline until the access completes.

## Interface
- TIMEOUT_CYCLES, 16, number of REQ-state cycles without `mem_ready` before an access is aborted (used only with MEM_TIMEOUT_EN).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- RegWrite_mem, MemtoReg_mem, Branch_mem, Zero_mem, MemWrite_mem, MemRead_mem, is_greater_mem  in  1 each  EX/MEM control and flag outputs.
- immvalue_added_pc_mem  in  64  branch target.
- ALU_result_mem  in  64  memory address / ALU result.
- WriteData_mem  in  64  store data.
- function_code_mem  in  4  {funct7[5], funct3}.
- destination_reg_mem  in  5  rd.
- mem_req  out  1  access request; equals (state==REQ).
- mem_we  out  1  equals MemWrite_mem.
- mem_size  out  2  equals function_code_mem[1:0].
- mem_addr  out  64  equals ALU_result_mem.
- mem_wdata  out  64  equals WriteData_mem.
- mem_ready  in  1  the access completes on a rising edge where mem_req=1 and mem_ready=1.
- mem_rdata  in  64  load data, valid when mem_ready=1.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  take branch.
- branch_target  out  64  equals immvalue_added_pc_mem.
- Flush  out  1  flushes IF/ID, ID/EX and EX/MEM; equals PCSrc.
- RegWrite_wb, MemtoReg_wb  out  1 each  MEM/WB controls.
- ReadData_wb, ALU_result_wb  out  64 each  MEM/WB data.
- destination_reg_wb  out  5  MEM/WB rd.
- mem_error  out  1  sticky access-timeout flag.

## Operation
- The FSM has three states: IDLE, REQ, DONE. Reset puts the FSM in IDLE.
- Reset value of every registered output is 0. `mem_req`, `stall`, `PCSrc` and `Flush` are therefore 0 during reset.
- Define memop = MemRead_mem | MemWrite_mem.
- IDLE with memop:
  - stall=1; next state REQ.
  - MEM/WB loads a bubble: RegWrite_wb=0, MemtoReg_wb=0; the other WB fields hold.
- IDLE without memop:
  - stall=0; the instruction retires.
  - MEM/WB loads {RegWrite_mem, MemtoReg_mem, ALU_result_mem, destination_reg_mem}.
  - ReadData_wb loads 0.
- REQ:
  - stall=1 and mem_req=1; address and data are held stable by the stall.
  - MEM/WB loads a bubble each cycle.
  - On mem_ready=1: capture mem_rdata into an internal latch (capture 0 for a store); next state DONE.
- DONE:
  - stall=0; retire as in IDLE, except ReadData_wb loads the latched data; next state IDLE.
- Branch resolution, evaluated only in IDLE; taken is decided on function_code_mem[2:0]:
  - 000 (beq): taken = Zero.
  - 001 (bne): taken = !Zero.
  - 100 (blt): taken = !is_greater & !Zero.
  - 101 (bge): taken = is_greater | Zero.
  - All other codes: not taken.
- PCSrc = Branch_mem & taken & (state==IDLE) & !memop. PCSrc, Flush and branch_target are combinational.
- Simultaneous Branch_mem and memop is illegal. memop wins and PCSrc=0.

## Timing
- Non-memory instruction: 1 cycle in the stage; WB fields valid the cycle after.
- Memory access with a ready response after k REQ-cycles (k≥1): the stage occupies 2+k cycles (IDLE, k×REQ, DONE) and stall is high for 1+k cycles.
- Back-to-back memory ops: the DONE edge advances EX/MEM, and the next op starts in IDLE the following cycle.
- mem_ready outside REQ is ignored.
- Reset mid-access: mem_req deasserts immediately (asynchronous) and the access is abandoned.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter (clog2(TIMEOUT_CYCLES) bits) clears on entering REQ and increments each REQ cycle with mem_ready=0.
  - On reaching TIMEOUT_CYCLES, the access is aborted: next state DONE, the latch captures 0, and RegWrite_wb loads 0 at that retire.
  - mem_error is set and stays 1 until reset.
- MEM_TIMEOUT_EN undefined: the block waits indefinitely in REQ, no counter exists, and mem_error is tied to 0.

## Test plan
- Reset: assert reset mid-REQ → mem_req, stall and all WB outputs are 0 immediately; state is IDLE after release.
- ALU op: RegWrite_mem=1, ALU_result_mem=0x2A, rd=5 → next cycle RegWrite_wb=1, ALU_result_wb=0x2A, destination_reg_wb=5, stall never asserted.
- Load with mem_ready after 3 REQ-cycles, mem_rdata=0xDEADBEEF → stall high for exactly 4 cycles, mem_req high 3 cycles, ReadData_wb=0xDEADBEEF after DONE, RegWrite_wb=0 during stall.
- Branches (Branch_mem=1, immvalue_added_pc_mem=0x100):
  - beq with Zero=1 → PCSrc=Flush=1, branch_target=0x100.
  - bne with Zero=1 → PCSrc=0.
  - bge with is_greater=1 → PCSrc=1.
- Back-to-back store then load, each with single-cycle ready → mem_req pulses once per op, total 6 cycles.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held at 0 → abort after 4 REQ cycles, mem_error=1 and remains 1, RegWrite_wb=0 for that load.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with ready-handshaked data access, branch resolution and MEM/WB register
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES REQ cycles without mem_ready.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_mem,
    input  logic        MemtoReg_mem,
    input  logic        Branch_mem,
    input  logic        Zero_mem,
    input  logic        MemWrite_mem,
    input  logic        MemRead_mem,
    input  logic        is_greater_mem,
    input  logic [63:0] immvalue_added_pc_mem,
    input  logic [63:0] ALU_result_mem,
    input  logic [63:0] WriteData_mem,
    input  logic [3:0]  function_code_mem,
    input  logic [4:0]  destination_reg_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        Flush,
    output logic        RegWrite_wb,
    output logic        MemtoReg_wb,
    output logic [63:0] ReadData_wb,
    output logic [63:0] ALU_result_wb,
    output logic [4:0]  destination_reg_wb,
    output logic        mem_error
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
    logic [1:0]  state, state_nx;
    logic [63:0] rdata_q;
    logic [2:0]  f3;
    logic        memop, taken, retire, abort, aborted;
    logic        unused;
    assign memop         = MemRead_mem | MemWrite_mem;
    assign f3            = function_code_mem[2:0];
    assign unused        = function_code_mem[3];
    assign mem_we        = MemWrite_mem;
    assign mem_size      = function_code_mem[1:0];
    assign mem_addr      = ALU_result_mem;
    assign mem_wdata     = WriteData_mem;
    assign branch_target = immvalue_added_pc_mem;
    assign taken = f3 == 3'b000 ? Zero_mem :
                   f3 == 3'b001 ? !Zero_mem :
                   f3 == 3'b100 ? !is_greater_mem & !Zero_mem :
                   f3 == 3'b101 ? is_greater_mem | Zero_mem : 1'b0;
    assign mem_req = state == REQ;
    // Gated by reset so the front end sees no stall or redirect while the stage is held in reset
    assign stall   = !reset & (mem_req | (state == IDLE & memop));
    assign PCSrc   = !reset & Branch_mem & taken & (state == IDLE) & !memop;
    assign Flush   = PCSrc;
    assign retire  = (state == IDLE & !memop) | (state == DONE);
    assign state_nx = state == IDLE ? (memop ? REQ : IDLE) :
                      state == REQ  ? ((mem_ready | abort) ? DONE : REQ) : IDLE;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic          err_q;
    assign abort     = mem_req & !mem_ready & (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign mem_error = err_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt     <= '0;
            aborted <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt     <= (mem_req & !mem_ready) ? cnt + 1'b1 : '0;
            aborted <= abort;
            err_q   <= err_q | abort;
        end
`else
    assign abort     = 1'b0;
    assign aborted   = 1'b0;
    assign mem_error = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state              <= IDLE;
            rdata_q            <= '0;
            RegWrite_wb        <= 1'b0;
            MemtoReg_wb        <= 1'b0;
            ReadData_wb        <= '0;
            ALU_result_wb      <= '0;
            destination_reg_wb <= '0;
        end else begin
            state <= state_nx;
            if (mem_req & (mem_ready | abort))
                rdata_q <= (MemWrite_mem | !mem_ready) ? '0 : mem_rdata;
            RegWrite_wb <= retire & RegWrite_mem & !aborted;
            MemtoReg_wb <= retire & MemtoReg_mem;
            if (retire) begin
                ALU_result_wb      <= ALU_result_mem;
                destination_reg_wb <= destination_reg_mem;
                ReadData_wb        <= state == DONE ? rdata_q : '0;
            end
        end
endmodule
